decode_sram_sequencer: RTL
==========================

Name: decode_sram_sequencer

Overview:
- Top-level milestone scheduler and single-port SRAM arbiter for the decompressor.
- Sequences four phases: UART image load, then M2 (IDCT/dequant, writes YUV), then M1 (interpolation + CSC, writes RGB), then VGA display.
- Owns the SRAM_controller port and grants it to exactly one client at a time.
- Replaces the ad-hoc top_state mux in project; sits between the clients (UART_SRAM_interface, M1, M2, VGA_SRAM_interface) and SRAM_controller.

Parameters:
- UART_TIMEOUT, 49999999, idle cycles after the last UART write that end the load phase.
- MS_TIMEOUT, 2**24-1, maximum cycles allowed between a milestone start and its done before the block enters the error state.
- CNT_W, 32, width of the per-milestone cycle counters.

Ports:
- CLOCK_50_I  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- uart_start_n  in  1  raw UART_RX_I line; low in IDLE/DONE/ERROR = start bit
- uart_addr  in  18  UART client SRAM address
- uart_wdata  in  16  UART client write data
- uart_we_n  in  1  UART client write enable, active low
- uart_init  out  1  one-cycle pulse on UART entry
- uart_enable  out  1  high from the cycle after uart_init until UART exit
- m2_addr / m1_addr  in  18  milestone SRAM address
- m2_wdata / m1_wdata  in  16  milestone write data
- m2_we_n / m1_we_n  in  1  milestone write enable, active low
- m2_start / m1_start  out  1  one-cycle start pulse
- m2_done / m1_done  in  1  one-cycle completion pulse
- vga_addr  in  18  VGA client address (read-only)
- VGA_enable  out  1  VGA unit enable
- SRAM_address  out  18  to SRAM_controller
- SRAM_write_data  out  16  to SRAM_controller
- SRAM_we_n  out  1  to SRAM_controller
- seq_state  out  3  current state encoding (LED/debug)
- m2_cycles / m1_cycles  out  CNT_W  cycles from start pulse to done, saturating
- seq_error  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - state S_IDLE; owner VGA; VGA_enable=1.
  - Starts, uart_init, uart_enable = 0; seq_error=0; counters 0.
  - SRAM_we_n=1, SRAM_address=vga_addr (combinational owner mux).
- States and seq_state encoding: S_IDLE 0, S_UART 1, S_M2_START 2, S_M2_WAIT 3, S_M1_START 4, S_M1_WAIT 5, S_DONE 6, S_ERROR 7.
- S_IDLE / S_DONE / S_ERROR: owner VGA, VGA_enable=1. If uart_start_n=0, the next cycle is a guard cycle, then S_UART with uart_init pulsed.
  - Entering S_UART clears seq_error and both counters.
- S_UART: owner UART, VGA_enable=0.
  - Internal timer resets on every uart_we_n=0 cycle, otherwise increments.
  - Timer == UART_TIMEOUT: guard cycle, then S_M2_START.
- S_Mx_START:
  - Mx_start=1 for exactly this cycle; owner Mx.
  - Clear the Mx counter and watchdog.
  - Next state S_Mx_WAIT.
- S_Mx_WAIT:
  - Mx counter increments each cycle, saturating at all-ones.
  - Watchdog increments each cycle.
  - On Mx_done: M2 goes through a guard cycle to S_M1_START; M1 goes through a guard cycle to S_DONE.
  - Watchdog == MS_TIMEOUT with no done: seq_error=1, guard cycle, then S_ERROR.
  - done arriving in the same cycle as the timeout: done wins.
- Guard cycle:
  - Owner NONE: SRAM_we_n=1, SRAM_address=0, write data 0.
  - Exactly one cycle on every owner change. This drains the SRAM_controller's registered path so no write from the old owner lands under the new one.
- Arbitration:
  - Owner is a registered field; the SRAM mux is combinational on it.
  - A non-owner's we_n is ignored, never forwarded.
  - VGA never writes: we_n forced 1 while owner is VGA.
- Unsolicited pulses: m1_done/m2_done outside the matching WAIT state are ignored; counters are not affected.
- uart_start_n low while in S_UART/M2/M1 is ignored; no restart mid-decode.
- Reset mid-operation: asynchronous return to reset values within the reset cycle; no start pulse is emitted on reset release.

Decomposition:
- Shared package (define_state.h): seq_state_type enum with the values above; sram_owner_type {OWN_NONE, OWN_VGA, OWN_UART, OWN_M1, OWN_M2}; U/V/Y/RGB segment start-address constants.
- Sub-module sram_port_mux: purely combinational owner-select of address, data and we_n. Instantiated once.
- The state machine, timers and counters stay in decode_sram_sequencer.

Test Plan:
- Full sequence (UART_TIMEOUT=20): uart_start_n low in IDLE, 5 UART writes, then silence.
  - Required: seq_state 1 → 2 exactly 21 cycles after the last write (20 timer + 1 guard).
  - Required: m2_start a single pulse; m2_done 100 cycles later → one guard cycle → m1_start; m1_done 50 cycles later → S_DONE.
  - Required: m2_cycles=100, m1_cycles=50, VGA_enable=1.
- Arbitration isolation: in S_M2_WAIT, drive m1_we_n=0 and uart_we_n=0 with distinct addresses.
  - Required: SRAM_address=m2_addr and SRAM_we_n=m2_we_n every cycle.
  - Required: at the guard cycle, SRAM_we_n=1 and SRAM_address=0.
- Watchdog (MS_TIMEOUT=30): no m2_done.
  - Required: seq_error=1 at cycle 30, state 7 after the guard cycle, VGA_enable=1.
  - Then uart_start_n=0 → S_UART and seq_error cleared.
- Done/timeout collision: m1_done asserted in the cycle the watchdog reaches MS_TIMEOUT → S_DONE, seq_error=0.
- Spurious pulses: m1_done pulsed in S_M2_WAIT and m2_done pulsed in S_IDLE → no state change, counters unaffected.
- Reset mid-M1: resetn low at S_M1_WAIT cycle 10 → immediately state 0, SRAM_we_n=1, VGA_enable=1; no m1_start or m2_start after release.

Source files
------------

// File: rtl/decode_sram_sequencer_pkg.sv
// Shared types and constants for the decompressor top-level sequencer:
// milestone states, SRAM port owners and the image segment base addresses.
package decode_sram_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UART     = 3'd1,
    S_M2_START = 3'd2,
    S_M2_WAIT  = 3'd3,
    S_M1_START = 3'd4,
    S_M1_WAIT  = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } seq_state_type;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_UART,
    OWN_M1,
    OWN_M2
  } sram_owner_type;

  // SRAM segment start addresses (16-bit words).
  localparam logic [17:0] SEG_Y_START   = 18'd0;
  localparam logic [17:0] SEG_U_START   = 18'd38400;
  localparam logic [17:0] SEG_V_START   = 18'd57600;
  localparam logic [17:0] SEG_RGB_START = 18'd146944;

  // Client that owns the SRAM port while the sequencer sits in a given state.
  function automatic sram_owner_type owner_of(input seq_state_type s);
    case (s)
      S_UART:                 return OWN_UART;
      S_M2_START, S_M2_WAIT:  return OWN_M2;
      S_M1_START, S_M1_WAIT:  return OWN_M1;
      default:                return OWN_VGA;
    endcase
  endfunction

endpackage

// File: rtl/decode_sram_sequencer_sram_port_mux.sv
// Combinational owner-select of the single SRAM_controller port. Only the
// current owner's request reaches the controller; with no owner the port is
// parked at address 0, data 0, no write.
module sram_port_mux
  import decode_sram_sequencer_pkg::*;
(
  input  sram_owner_type owner,
  input  logic [17:0]    uart_addr,
  input  logic [15:0]    uart_wdata,
  input  logic           uart_we_n,
  input  logic [17:0]    m1_addr,
  input  logic [15:0]    m1_wdata,
  input  logic           m1_we_n,
  input  logic [17:0]    m2_addr,
  input  logic [15:0]    m2_wdata,
  input  logic           m2_we_n,
  input  logic [17:0]    vga_addr,
  output logic [17:0]    sram_addr,
  output logic [15:0]    sram_wdata,
  output logic           sram_we_n
);

  // Route the owner's address/data/we_n; VGA is a read-only client.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (owner)
      OWN_VGA:  sram_addr = vga_addr;
      OWN_UART: begin
        sram_addr  = uart_addr;
        sram_wdata = uart_wdata;
        sram_we_n  = uart_we_n;
      end
      OWN_M1: begin
        sram_addr  = m1_addr;
        sram_wdata = m1_wdata;
        sram_we_n  = m1_we_n;
      end
      OWN_M2: begin
        sram_addr  = m2_addr;
        sram_wdata = m2_wdata;
        sram_we_n  = m2_we_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_sram_sequencer.sv
// Top-level milestone scheduler: UART load -> M2 -> M1 -> VGA display.
// Owns the SRAM port and hands it to one client at a time, always through a
// single owner-NONE guard cycle so the controller's registered path drains
// before the next owner drives it.
module decode_sram_sequencer
  import decode_sram_sequencer_pkg::*;
#(
  parameter int UART_TIMEOUT = 49999999,
  parameter int MS_TIMEOUT   = 2**24-1,
  parameter int CNT_W        = 32
) (
  input  logic             CLOCK_50_I,
  input  logic             resetn,
  input  logic             uart_start_n,
  input  logic [17:0]      uart_addr,
  input  logic [15:0]      uart_wdata,
  input  logic             uart_we_n,
  output logic             uart_init,
  output logic             uart_enable,
  input  logic [17:0]      m2_addr,
  input  logic [15:0]      m2_wdata,
  input  logic             m2_we_n,
  output logic             m2_start,
  input  logic             m2_done,
  input  logic [17:0]      m1_addr,
  input  logic [15:0]      m1_wdata,
  input  logic             m1_we_n,
  output logic             m1_start,
  input  logic             m1_done,
  input  logic [17:0]      vga_addr,
  output logic             VGA_enable,
  output logic [17:0]      SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] m2_cycles,
  output logic [CNT_W-1:0] m1_cycles,
  output logic             seq_error
);

  localparam int UT_W = $clog2(UART_TIMEOUT + 1);
  localparam int WD_W = $clog2(MS_TIMEOUT + 1);
  localparam logic [UT_W-1:0] UART_LIMIT = UT_W'(UART_TIMEOUT);
  localparam logic [WD_W-1:0] MS_LIMIT   = WD_W'(MS_TIMEOUT);

  seq_state_type  state_q, state_d, pend_q, pend_d, go_to;
  sram_owner_type owner_q, owner_d;
  logic           guard_q, guard_d, go_guard;
  logic           uart_init_q, uart_init_d;
  logic           seq_error_q, seq_error_d;
  logic [UT_W-1:0]  uart_timer_q, uart_timer_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] m2_cnt_q, m2_cnt_d, m1_cnt_q, m1_cnt_d;

  // State, owner and timer registers.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pend_q       <= S_IDLE;
      owner_q      <= OWN_VGA;
      guard_q      <= 1'b0;
      uart_init_q  <= 1'b0;
      seq_error_q  <= 1'b0;
      uart_timer_q <= '0;
      wd_q         <= '0;
      m2_cnt_q     <= '0;
      m1_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q      <= state_d;
      pend_q       <= pend_d;
      owner_q      <= owner_d;
      guard_q      <= guard_d;
      uart_init_q  <= uart_init_d;
      seq_error_q  <= seq_error_d;
      uart_timer_q <= uart_timer_d;
      wd_q         <= wd_d;
      m2_cnt_q     <= m2_cnt_d;
      m1_cnt_q     <= m1_cnt_d;
    end
  end

  // Next-state logic: a transition that changes owner first parks the port
  // for one guard cycle, remembering the target state in pend_q.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    owner_d      = owner_q;
    guard_d      = 1'b0;
    uart_init_d  = 1'b0;
    seq_error_d  = seq_error_q;
    uart_timer_d = uart_timer_q;
    wd_d         = wd_q;
    m2_cnt_d     = m2_cnt_q;
    m1_cnt_d     = m1_cnt_q;
    go_guard     = 1'b0;
    go_to        = S_IDLE;

    if (guard_q) begin
      state_d = pend_q;
      owner_d = owner_of(pend_q);
      if (pend_q == S_UART) begin
        uart_init_d  = 1'b1;
        seq_error_d  = 1'b0;
        uart_timer_d = '0;
        m2_cnt_d     = '0;
        m1_cnt_d     = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (!uart_start_n) begin
            go_guard = 1'b1;
            go_to    = S_UART;
          end
        end
        S_UART: begin
          // Any write restarts the silence timer.
          uart_timer_d = uart_we_n ? uart_timer_q + UT_W'(1) : '0;
          if (uart_timer_d == UART_LIMIT) begin
            go_guard = 1'b1;
            go_to    = S_M2_START;
          end
        end
        S_M2_START: begin
          m2_cnt_d = '0;
          wd_d     = '0;
          state_d  = S_M2_WAIT;
        end
        S_M2_WAIT: begin
          m2_cnt_d = (m2_cnt_q == '1) ? m2_cnt_q : m2_cnt_q + CNT_W'(1);
          wd_d     = wd_q + WD_W'(1);
          go_guard = m2_done || (wd_d == MS_LIMIT);
          go_to    = m2_done ? S_M1_START : S_ERROR;
          // A done in the timeout cycle takes priority over the error.
          if (!m2_done && wd_d == MS_LIMIT) seq_error_d = 1'b1;
        end
        S_M1_START: begin
          m1_cnt_d = '0;
          wd_d     = '0;
          state_d  = S_M1_WAIT;
        end
        S_M1_WAIT: begin
          m1_cnt_d = (m1_cnt_q == '1) ? m1_cnt_q : m1_cnt_q + CNT_W'(1);
          wd_d     = wd_q + WD_W'(1);
          go_guard = m1_done || (wd_d == MS_LIMIT);
          go_to    = m1_done ? S_DONE : S_ERROR;
          if (!m1_done && wd_d == MS_LIMIT) seq_error_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (go_guard) begin
      guard_d = 1'b1;
      owner_d = OWN_NONE;
      pend_d  = go_to;
    end
  end

  sram_port_mux u_sram_port_mux (
    .owner      (owner_q),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_we_n  (uart_we_n),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_we_n    (m1_we_n),
    .m2_addr    (m2_addr),
    .m2_wdata   (m2_wdata),
    .m2_we_n    (m2_we_n),
    .vga_addr   (vga_addr),
    .sram_addr  (SRAM_address),
    .sram_wdata (SRAM_write_data),
    .sram_we_n  (SRAM_we_n)
  );

  assign seq_state   = state_q;
  assign uart_init   = uart_init_q;
  assign uart_enable = (state_q == S_UART) && !guard_q && !uart_init_q;
  assign m2_start    = (state_q == S_M2_START);
  assign m1_start    = (state_q == S_M1_START);
  assign VGA_enable  = (owner_q == OWN_VGA);
  assign m2_cycles   = m2_cnt_q;
  assign m1_cycles   = m1_cnt_q;
  assign seq_error   = seq_error_q;

endmodule
